// File: rtl/demux_rr_sched.sv
// rtl/demux_rr_sched.sv - 1x4 streaming demux scheduler, round-robin bursts or fixed select
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   mode                  0 = round-robin over enabled channels, 1 = fixed select
//   fixed_sel [1:0]       destination channel when mode=1
//   en_mask [3:0]         channel enables; disabled channels are never addressed
//   in_valid/in_ready     input handshake, in_data [DW-1:0] input beat
//   out_valid [3:0]       one-hot per-channel valid, out_data [DW-1:0] shared bus
//   out_ready [3:0]       per-channel ready
//   cur_sel [1:0]         destination of the held beat
//   busy                  a beat is held in the output register
module demux_rr_sched #(
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mode,
  input  logic [1:0]    fixed_sel,
  input  logic [3:0]    en_mask,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic [3:0]    out_valid,
  output logic [DW-1:0] out_data,
  input  logic [3:0]    out_ready,
  output logic [1:0]    cur_sel,
  output logic          busy
);

  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CW-1:0] LAST = CW'(BURST - 1);

  logic          full;
  logic [DW-1:0] data_q;
  logic [1:0]    dest_q;
  logic [1:0]    ptr;
  logic [CW-1:0] beat_cnt;
  logic          mode_q;

  logic [1:0]    rr_dest;
  logic [1:0]    cand;
  logic [1:0]    next_dest;
  logic          dest_ok;
  logic          fire;
  logic          take;
  logic [CW-1:0] cnt_eff;

  // First enabled channel at or after ptr. Scanning from the far end down
  // lets the nearest candidate win without a break.
  always_comb begin
    rr_dest = ptr;
    cand    = '0;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr + 2'(i);
      if (en_mask[cand]) rr_dest = cand;
    end
  end

  assign dest_ok   = mode ? en_mask[fixed_sel] : (en_mask != 4'b0000);
  assign next_dest = mode ? fixed_sel : rr_dest;

  assign fire     = full & out_ready[dest_q];
  assign in_ready = rst_n & dest_ok & (~full | fire);
  assign take     = in_valid & in_ready;

  // A mode change restarts the burst count; a take in that same cycle
  // already sees the cleared count.
  assign cnt_eff = (mode != mode_q) ? '0 : beat_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full     <= 1'b0;
      data_q   <= '0;
      dest_q   <= '0;
      ptr      <= '0;
      beat_cnt <= '0;
      mode_q   <= 1'b0;
    end else begin
      mode_q <= mode;
      if (take) begin
        full   <= 1'b1;
        data_q <= in_data;
        dest_q <= next_dest;
        if (!mode) begin
          if (cnt_eff == LAST) begin
            beat_cnt <= '0;
            ptr      <= next_dest + 2'd1;
          end else begin
            beat_cnt <= cnt_eff + 1'b1;
            ptr      <= next_dest;
          end
        end else begin
          beat_cnt <= '0;
        end
      end else begin
        if (fire) full <= 1'b0;
        if (mode != mode_q) beat_cnt <= '0;
      end
    end
  end

  assign out_valid = full ? (4'b0001 << dest_q) : 4'b0000;
  assign out_data  = data_q;
  assign cur_sel   = dest_q;
  assign busy      = full;

endmodule

// File: tb/tb_demux_rr_sched.sv
// tb/tb_demux_rr_sched.sv - self-checking bench for demux_rr_sched with a behavioural model
module tb_demux_rr_sched;

  localparam int DW = 8;
  localparam int BURST = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mode;
  logic [1:0]    fixed_sel;
  logic [3:0]    en_mask;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [3:0]    out_ready;

  logic          in_ready,  in_ready_b;
  logic [3:0]    out_valid, out_valid_b;
  logic [DW-1:0] out_data,  out_data_b;
  logic [1:0]    cur_sel,   cur_sel_b;
  logic          busy,      busy_b;

  always #5 clk = ~clk;

  demux_rr_sched #(.DW(DW), .BURST(BURST)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .fixed_sel(fixed_sel), .en_mask(en_mask),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .cur_sel(cur_sel), .busy(busy)
  );

  demux_rr_sched #(.DW(DW), .BURST(2)) dut_b2 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .fixed_sel(fixed_sel), .en_mask(en_mask),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_b),
    .out_valid(out_valid_b), .out_data(out_data_b), .out_ready(out_ready),
    .cur_sel(cur_sel_b), .busy(busy_b)
  );

  int checks = 0;
  int failures = 0;

  int m_full, m_data, m_dest, m_ptr, m_cnt, m_mode_prev;
  int log_a[$];
  int log_b[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int onehot_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_full = 0; m_data = 0; m_dest = 0; m_ptr = 0; m_cnt = 0; m_mode_prev = 0;
  endtask

  task automatic check_log(input string tag, input int got[$], input int exp[$]);
    check({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s_%0d", tag, i), got[i], exp[i]);
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    int ok, nd, exp_rdy, take, fire, cnt_eff, c;
    #1;
    if (!rst_n) begin
      model_reset();
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_busy", busy, 0);
      @(posedge clk);
      @(negedge clk);
      return;
    end
    if (mode) begin
      ok = en_mask[fixed_sel];
      nd = fixed_sel;
    end else begin
      ok = (en_mask != 4'b0000);
      nd = m_ptr;
      for (int k = 3; k >= 0; k--) begin
        c = (m_ptr + k) % 4;
        if (en_mask[c]) nd = c;
      end
    end
    fire    = (m_full != 0) && out_ready[m_dest];
    exp_rdy = ok && (!m_full || fire);
    take    = in_valid && exp_rdy;
    check("in_ready", in_ready, exp_rdy);
    check("out_valid", out_valid, m_full ? (1 << m_dest) : 0);
    check("out_data", out_data, m_data);
    check("cur_sel", cur_sel, m_dest);
    check("busy", busy, m_full);
    if ((out_valid & out_ready) != 0) log_a.push_back(onehot_idx(out_valid));
    if ((out_valid_b & out_ready) != 0) log_b.push_back(onehot_idx(out_valid_b));
    @(posedge clk);
    cnt_eff = (mode != m_mode_prev) ? 0 : m_cnt;
    if (take) begin
      m_full = 1; m_data = in_data; m_dest = nd;
      if (!mode) begin
        if (cnt_eff == BURST - 1) begin
          m_cnt = 0; m_ptr = (nd + 1) % 4;
        end else begin
          m_cnt = cnt_eff + 1; m_ptr = nd;
        end
      end else begin
        m_cnt = 0;
      end
    end else begin
      if (fire) m_full = 0;
      if (mode != m_mode_prev) m_cnt = 0;
    end
    m_mode_prev = mode;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  int exp_q[$];

  initial begin
    rst_n = 1'b0; mode = 1'b0; fixed_sel = 2'd0; en_mask = 4'hF;
    in_valid = 1'b0; in_data = '0; out_ready = 4'hF;
    model_reset();
    @(negedge clk);
    do_reset();

    // Full RR bursts across all four channels
    log_a.delete(); log_b.delete();
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = DW'(i);
      step();
    end
    in_valid = 1'b0;
    step(); step();
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(i / 4);
    check_log("t1_dest", log_a, exp_q);

    // Sparse mask: BURST=4 and BURST=2 instances side by side
    do_reset();
    en_mask = 4'b0101;
    log_a.delete(); log_b.delete();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = DW'(8'h40 + i);
      step();
    end
    in_valid = 1'b0;
    step(); step();
    exp_q = '{0, 0, 0, 0, 2, 2, 2, 2};
    check_log("t2_dest_b4", log_a, exp_q);
    exp_q = '{0, 0, 2, 2, 0, 0, 2, 2};
    check_log("t2_dest_b2", log_b, exp_q);

    // Fixed select with back-pressure on the selected channel
    do_reset();
    mode = 1'b1; fixed_sel = 2'd2; en_mask = 4'hF;
    in_valid = 1'b1; in_data = 8'hA5;
    step();
    out_ready = 4'b1011; in_data = 8'h3C;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t3_hold_valid", out_valid, 4'b0100);
      check("t3_hold_data", out_data, 8'hA5);
      check("t3_hold_ready", in_ready, 0);
      step();
    end
    out_ready = 4'hF;
    #1 check("t3_release_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    #1;
    check("t3_next_valid", out_valid, 4'b0100);
    check("t3_next_data", out_data, 8'h3C);
    step(); step();

    // Fixed select onto a disabled channel stalls until enabled
    fixed_sel = 2'd3; en_mask = 4'b0111; in_valid = 1'b1; in_data = 8'h77;
    #1;
    check("t4_stall_ready", in_ready, 0);
    check("t4_stall_valid", out_valid, 0);
    step(); step();
    en_mask = 4'hF;
    #1 check("t4_resume_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    step(); step();

    // Asynchronous reset with a beat held mid-burst
    do_reset();
    mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = DW'(8'h10 + i);
      step();
    end
    in_valid = 1'b0; out_ready = 4'h0;
    step();
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_valid", out_valid, 0);
    check("t5_async_busy", busy, 0);
    check("t5_async_ready", in_ready, 0);
    model_reset();
    @(negedge clk);
    step();
    rst_n = 1'b1; out_ready = 4'hF;
    log_a.delete(); log_b.delete();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = DW'(8'h20 + i);
      step();
    end
    in_valid = 1'b0;
    step(); step();
    exp_q = '{0, 0, 0, 0, 1};
    check_log("t5_dest", log_a, exp_q);

    // Mode switch mid-burst keeps ptr and restarts the burst
    do_reset();
    log_a.delete(); log_b.delete();
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = DW'(8'h60 + i);
      step();
    end
    mode = 1'b1; fixed_sel = 2'd0;
    for (int i = 0; i < 3; i++) begin
      in_data = DW'(8'h70 + i);
      step();
    end
    mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_data = DW'(8'h80 + i);
      step();
    end
    in_valid = 1'b0;
    step(); step();
    exp_q = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 1, 1, 2};
    check_log("t6_dest", log_a, exp_q);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      if ($urandom_range(0, 9) == 0) en_mask = 4'($urandom);
      if ($urandom_range(0, 7) == 0) fixed_sel = 2'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = DW'($urandom);
      out_ready = 4'($urandom) | ($urandom_range(0, 1) ? 4'hF : 4'h0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
